// File: rtl/mem_bus_arbiter_pkg.sv
// Shared configuration for the memory-port arbiter: default sizing and the
// arbiter state encoding. No ports; imported by mem_bus_arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF       = 32;
    localparam int unsigned DATA_W_DEF       = 32;
    localparam int unsigned BURST_LEN_DEF    = 4;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    // One-hot so any corrupted pattern is caught by the default arm and
    // steered back to IDLE.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_GRANT_I = 4'b0010,
        ST_GRANT_D = 4'b0100,
        ST_DONE    = 4'b1000
    } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one main-memory port between I-cache refill bursts and D-cache
// refill/writeback bursts. D has fixed priority; once D has won STARVE_LIMIT
// bursts in a row while I was waiting, I is forced through.
//
// Ports:
//   clock, reset           posedge clock, async active-low reset
//   i_req/i_addr           I read-burst request (level) and base address
//   i_gnt/i_rvalid/i_rdata I owns the port / read beat valid / read data
//   i_done                 one-cycle pulse at end of an I burst
//   d_req/d_we/d_addr      D burst request, write flag, base address
//   d_wdata                D write beat for the index shown on d_beat
//   d_gnt/d_beat           D owns the port / current beat index
//   d_rvalid/d_rdata       D refill beat valid / read data
//   d_done                 one-cycle pulse at end of a D burst
//   mem_req/mem_we         beat request / beat is a write
//   mem_addr/mem_wdata     beat address / beat write data
//   mem_ready/mem_rdata    beat completed / read data
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned BURST_LEN    = BURST_LEN_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_req,
    input  logic [ADDR_W-1:0]            i_addr,
    output logic                         i_gnt,
    output logic                         i_rvalid,
    output logic [DATA_W-1:0]            i_rdata,
    output logic                         i_done,
    input  logic                         d_req,
    input  logic                         d_we,
    input  logic [ADDR_W-1:0]            d_addr,
    input  logic [DATA_W-1:0]            d_wdata,
    output logic                         d_gnt,
    output logic [$clog2(BURST_LEN)-1:0] d_beat,
    output logic                         d_rvalid,
    output logic [DATA_W-1:0]            d_rdata,
    output logic                         d_done,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_ready,
    input  logic [DATA_W-1:0]            mem_rdata
);

    localparam int unsigned BEAT_W   = $clog2(BURST_LEN);
    localparam int unsigned STEP     = DATA_W / 8;
    localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);

    // Burst base is aligned to the whole burst footprint.
    localparam logic [ADDR_W-1:0]   ALIGN_MASK = ~ADDR_W'(BURST_LEN * STEP - 1);
    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    arb_state_e          state;
    logic [BEAT_W-1:0]   beat;
    logic [STREAK_W-1:0] streak;
    logic [ADDR_W-1:0]   base;
    logic                we;
    logic                own_d;   // which side owns the DONE cycle

    logic i_starved;
    assign i_starved = i_req && (streak == STREAK_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            beat   <= '0;
            streak <= '0;
            base   <= '0;
            we     <= 1'b0;
            own_d  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (d_req && !i_starved) begin
                        state <= ST_GRANT_D;
                        own_d <= 1'b1;
                        base  <= d_addr & ALIGN_MASK;
                        we    <= d_we;
                        // Streak only counts D wins that made I wait.
                        if (!i_req)
                            streak <= '0;
                        else if (streak != STREAK_MAX)
                            streak <= streak + 1'b1;
                    end else if (i_req) begin
                        state  <= ST_GRANT_I;
                        own_d  <= 1'b0;
                        base   <= i_addr & ALIGN_MASK;
                        we     <= 1'b0;
                        streak <= '0;
                    end
                end
                ST_GRANT_I, ST_GRANT_D: begin
                    // Beat counter wraps to 0 on the last beat (power-of-2 length).
                    if (mem_ready) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT)
                            state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic in_gi, in_gd, in_done;
    assign in_gi   = (state == ST_GRANT_I);
    assign in_gd   = (state == ST_GRANT_D);
    assign in_done = (state == ST_DONE);

    assign i_gnt  = in_gi | (in_done & ~own_d);
    assign d_gnt  = in_gd | (in_done &  own_d);
    assign i_done = in_done & ~own_d;
    assign d_done = in_done &  own_d;

    assign mem_req   = in_gi | in_gd;
    assign mem_we    = in_gd & we;
    assign mem_addr  = mem_req ? (base + ADDR_W'(beat) * ADDR_W'(STEP)) : '0;
    assign mem_wdata = mem_we ? d_wdata : '0;
    assign d_beat    = in_gd ? beat : '0;

    // Read data is gated to the owning reader so idle/reset outputs stay 0.
    assign i_rvalid = in_gi & mem_ready;
    assign i_rdata  = in_gi ? mem_rdata : '0;
    assign d_rvalid = in_gd & ~we & mem_ready;
    assign d_rdata  = (in_gd & ~we) ? mem_rdata : '0;

endmodule
